// File: rtl/ltc2600_pkg.sv
// Shared types and constants for the LTC2600 device-side SPI responder.
//   cmd_t        : 4-bit command nibble encodings
//   resp_state_t : responder FSM states
//   frame_t      : 24-bit command frame layout {cmd, addr, data}
package ltc2600_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned BITCNT_W   = 5;
  localparam int unsigned CMD_W      = 4;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned FDATA_W    = 16;
  localparam int unsigned STAT_W     = 16;

  localparam logic [ADDR_W-1:0] ADDR_ALL = 4'hF;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_IN      = 4'h0,
    CMD_UPD        = 4'h1,
    CMD_WR_UPD_ALL = 4'h2,
    CMD_WR_UPD     = 4'h3,
    CMD_PD         = 4'h4,
    CMD_NOP        = 4'hF
  } cmd_t;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_SHIFT,
    ST_APPLY
  } resp_state_t;

  typedef struct packed {
    logic [CMD_W-1:0]   cmd;
    logic [ADDR_W-1:0]  addr;
    logic [FDATA_W-1:0] data;
  } frame_t;

  // True for the command nibbles the device understands.
  function automatic logic cmd_known(input logic [CMD_W-1:0] c);
    logic known;
    case (c)
      CMD_WR_IN, CMD_UPD, CMD_WR_UPD_ALL, CMD_WR_UPD, CMD_PD, CMD_NOP: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/ltc2600_spi_sync.sv
// Input conditioning for the LTC2600 responder.
// Synchronizes sck/sdi/csb/clrb into clk and derives single-cycle edge pulses.
// Ports:
//   clk, rstn                 : system clock, async active-low reset
//   sck, sdi, csb, clrb       : raw SPI / clear pins
//   sdi_s, csb_s, clrb_s      : synchronized levels
//   sck_rise_c / sck_fall_c   : combinational sck edge pulses
//   csb_rise_c / csb_fall_c   : combinational csb edge pulses
module ltc2600_spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic sck,
  input  logic sdi,
  input  logic csb,
  input  logic clrb,
  output logic sdi_s,
  output logic csb_s,
  output logic clrb_s,
  output logic sck_rise_c,
  output logic sck_fall_c,
  output logic csb_rise_c,
  output logic csb_fall_c
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] clrb_sync_q, clrb_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   csb_prev_q, csb_prev_d;
  logic                   sck_s;

  // Shift each pin into its chain; the top bit is the synchronized level.
  always_comb begin
    sck_sync_d  = SYNC_STAGES'({sck_sync_q, sck});
    sdi_sync_d  = SYNC_STAGES'({sdi_sync_q, sdi});
    csb_sync_d  = SYNC_STAGES'({csb_sync_q, csb});
    clrb_sync_d = SYNC_STAGES'({clrb_sync_q, clrb});
    sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
    csb_prev_d  = csb_sync_q[SYNC_STAGES-1];
  end

  // csb chain resets low so a frame already in progress keeps the FSM waiting
  // for a genuine high level; clrb resets inactive to avoid a spurious clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_sync_q  <= '0;
      sdi_sync_q  <= '0;
      csb_sync_q  <= '0;
      clrb_sync_q <= '1;
      sck_prev_q  <= 1'b0;
      csb_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      csb_sync_q  <= csb_sync_d;
      clrb_sync_q <= clrb_sync_d;
      sck_prev_q  <= sck_prev_d;
      csb_prev_q  <= csb_prev_d;
    end
  end

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
  assign csb_s      = csb_sync_q[SYNC_STAGES-1];
  assign clrb_s     = clrb_sync_q[SYNC_STAGES-1];
  assign sck_rise_c = sck_s & ~sck_prev_q;
  assign sck_fall_c = ~sck_s & sck_prev_q;
  assign csb_rise_c = csb_s & ~csb_prev_q;
  assign csb_fall_c = ~csb_s & csb_prev_q;

endmodule

// File: rtl/ltc2600_spi_responder.sv
// LTC2600 device-side emulator: receives 24-bit (or 32-bit) SPI command frames,
// keeps N_CH input/DAC registers and power-down flags, echoes the previous
// frame on sdo for daisy chaining.
// Ports:
//   clk, rstn        : system clock, async active-low reset
//   sck, sdi, csb    : SPI slave pins (csb active low)
//   clrb             : active-low clear of all input/DAC registers
//   sdo              : daisy-chain echo (previous frame, MSB first)
//   dac_code         : DAC registers, channel 0 in the LSBs
//   pd               : per-channel power-down flags
//   frame_valid      : pulse, a frame of >= 24 bits was applied
//   frame_error      : pulse, a frame had < 24 bits
//   cmd_ignored      : pulse, unknown command or out-of-range address
// Optional (macro LTC2600_RESP_STATS_EN): frame_count, error_count wrapping counters.
module ltc2600_spi_responder
  import ltc2600_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sck,
  input  logic                       sdi,
  input  logic                       csb,
  input  logic                       clrb,
  output logic                       sdo,
  output logic [N_CH*DATA_WIDTH-1:0] dac_code,
  output logic [N_CH-1:0]            pd,
  output logic                       frame_valid,
  output logic                       frame_error,
  output logic                       cmd_ignored
`ifdef LTC2600_RESP_STATS_EN
  ,
  output logic [STAT_W-1:0]          frame_count,
  output logic [STAT_W-1:0]          error_count
`endif
);

  logic sdi_s, csb_s, clrb_s;
  logic sck_rise_c, sck_fall_c, csb_rise_c, csb_fall_c;

  ltc2600_spi_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .sck        (sck),
    .sdi        (sdi),
    .csb        (csb),
    .clrb       (clrb),
    .sdi_s      (sdi_s),
    .csb_s      (csb_s),
    .clrb_s     (clrb_s),
    .sck_rise_c (sck_rise_c),
    .sck_fall_c (sck_fall_c),
    .csb_rise_c (csb_rise_c),
    .csb_fall_c (csb_fall_c)
  );

  resp_state_t                          state_q, state_d;
  logic [FRAME_BITS-1:0]                shreg_q, shreg_d;
  logic [BITCNT_W-1:0]                  bitcnt_q, bitcnt_d;
  logic                                 sdo_q, sdo_d;
  logic [N_CH-1:0][DATA_WIDTH-1:0]      in_q, in_d;
  logic [N_CH-1:0][DATA_WIDTH-1:0]      dac_q, dac_d;
  logic [N_CH-1:0]                      pd_q, pd_d;
  logic                                 frame_valid_q, frame_valid_d;
  logic                                 frame_error_q, frame_error_d;
  logic                                 cmd_ignored_q, cmd_ignored_d;

  frame_t                               frame;
  logic [DATA_WIDTH-1:0]                wdata;
  logic                                 addr_ok;
  logic [N_CH-1:0]                      sel;

  assign frame = frame_t'(shreg_q);
  assign wdata = DATA_WIDTH'(frame.data);

  // Next-state, shifting, command decode and register updates.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bitcnt_d      = bitcnt_q;
    sdo_d         = sdo_q;
    in_d          = in_q;
    dac_d         = dac_q;
    pd_d          = pd_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    cmd_ignored_d = 1'b0;
    sel           = '0;

    addr_ok = (frame.addr == ADDR_ALL) || (32'(frame.addr) < N_CH);
    if (frame.addr == ADDR_ALL) begin
      sel = '1;
    end else if (addr_ok) begin
      sel = N_CH'(1) << frame.addr;
    end

    case (state_q)
      ST_WAIT_IDLE: begin
        if (csb_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // Present the echo MSB before the first sck rise so the whole
        // previous frame replays MSB first.
        if (csb_fall_c) begin
          state_d  = ST_SHIFT;
          bitcnt_d = '0;
          sdo_d    = shreg_q[FRAME_BITS-1];
        end
      end
      ST_SHIFT: begin
        if (sck_rise_c) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], sdi_s};
          if (bitcnt_q != '1) begin
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
          end
        end
        if (sck_fall_c) begin
          sdo_d = shreg_q[FRAME_BITS-1];
        end
        if (csb_rise_c) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        if (bitcnt_q < BITCNT_W'(FRAME_BITS)) begin
          frame_error_d = 1'b1;
        end else begin
          frame_valid_d = 1'b1;
          if (!addr_ok || !cmd_known(frame.cmd)) begin
            cmd_ignored_d = 1'b1;
          end else if (clrb_s) begin
            for (int i = 0; i < N_CH; i++) begin
              if (sel[i]) begin
                case (frame.cmd)
                  CMD_WR_IN, CMD_WR_UPD_ALL: in_d[i] = wdata;
                  CMD_UPD: begin
                    dac_d[i] = in_q[i];
                    pd_d[i]  = 1'b0;
                  end
                  CMD_WR_UPD: begin
                    in_d[i]  = wdata;
                    dac_d[i] = wdata;
                    pd_d[i]  = 1'b0;
                  end
                  CMD_PD:  pd_d[i] = 1'b1;
                  default: ;
                endcase
              end
            end
            // Broadcast update uses the input registers after this frame's write.
            if (frame.cmd == CMD_WR_UPD_ALL) begin
              dac_d = in_d;
              pd_d  = '0;
            end
          end
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase

    // Clear overrides any write in the same cycle.
    if (!clrb_s) begin
      in_d  = '0;
      dac_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_WAIT_IDLE;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      sdo_q         <= 1'b0;
      in_q          <= '0;
      dac_q         <= '0;
      pd_q          <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      cmd_ignored_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      sdo_q         <= sdo_d;
      in_q          <= in_d;
      dac_q         <= dac_d;
      pd_q          <= pd_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      cmd_ignored_q <= cmd_ignored_d;
    end
  end

  assign sdo         = sdo_q;
  assign dac_code    = dac_q;
  assign pd          = pd_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign cmd_ignored = cmd_ignored_q;

`ifdef LTC2600_RESP_STATS_EN
  logic [STAT_W-1:0] frame_count_q, frame_count_d;
  logic [STAT_W-1:0] error_count_q, error_count_d;

  // Wrapping event counters, bumped on the same edge as their pulses.
  always_comb begin
    frame_count_d = frame_count_q + STAT_W'(frame_valid_d);
    error_count_d = error_count_q + STAT_W'(frame_error_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign error_count = error_count_q;
`endif

endmodule

// File: tb/tb_ltc2600_spi_responder.sv
// Self-checking bench for ltc2600_spi_responder: directed frames, randomized
// frames, clear behaviour and reset mid-frame, against a behavioural model.
module tb_ltc2600_spi_responder;

  localparam int HALF = 6;
  localparam int LAT  = 4;

  logic         clk = 1'b0;
  logic         rstn, sck, sdi, csb, clrb;
  logic         sdo;
  logic [127:0] dac_code;
  logic [7:0]   pd;
  logic         frame_valid, frame_error, cmd_ignored;
`ifdef LTC2600_RESP_STATS_EN
  logic [15:0]  frame_count, error_count;
`endif

  always #10 clk = ~clk;

  ltc2600_spi_responder dut (
    .clk         (clk),
    .rstn        (rstn),
    .sck         (sck),
    .sdi         (sdi),
    .csb         (csb),
    .clrb        (clrb),
    .sdo         (sdo),
    .dac_code    (dac_code),
    .pd          (pd),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .cmd_ignored (cmd_ignored)
`ifdef LTC2600_RESP_STATS_EN
    ,
    .frame_count (frame_count),
    .error_count (error_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural device model
  logic [15:0] in_m  [8];
  logic [15:0] dac_m [8];
  logic [7:0]  pd_m;
  logic [23:0] m_shreg;

  task automatic model_reset();
    for (int c = 0; c < 8; c++) begin
      in_m[c]  = '0;
      dac_m[c] = '0;
    end
    pd_m    = '0;
    m_shreg = '0;
  endtask

  function automatic logic [127:0] exp_dac();
    logic [127:0] v;
    for (int c = 0; c < 8; c++) v[c*16 +: 16] = dac_m[c];
    return v;
  endfunction

  // Shift the frame through the model and apply it; returns expected echo and pulses.
  task automatic model_frame(input logic [31:0] word, input int nbits, input bit clr,
                             output logic [31:0] esdo, output int ev, output int ee,
                             output int ei);
    logic [3:0]  c, a;
    logic [15:0] d;
    bit          aok, cok;
    esdo = '0; ev = 0; ee = 0; ei = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      esdo    = {esdo[30:0], m_shreg[23]};
      m_shreg = {m_shreg[22:0], word[i]};
    end
    if (nbits < 24) begin
      ee = 1;
      return;
    end
    ev  = 1;
    c   = m_shreg[23:20];
    a   = m_shreg[19:16];
    d   = m_shreg[15:0];
    aok = (a == 4'hF) || (a < 4'd8);
    cok = c inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
    if (!aok || !cok) begin
      ei = 1;
      return;
    end
    if (clr) return;
    for (int ch = 0; ch < 8; ch++) begin
      if (a == 4'hF || int'(a) == ch) begin
        case (c)
          4'h0, 4'h2: in_m[ch] = d;
          4'h1: begin dac_m[ch] = in_m[ch]; pd_m[ch] = 1'b0; end
          4'h3: begin in_m[ch] = d; dac_m[ch] = d; pd_m[ch] = 1'b0; end
          4'h4: pd_m[ch] = 1'b1;
          default: ;
        endcase
      end
    end
    if (c == 4'h2) begin
      for (int ch = 0; ch < 8; ch++) dac_m[ch] = in_m[ch];
      pd_m = '0;
    end
  endtask

  // Pin-level stimulus
  task automatic csb_low();
    @(negedge clk) csb = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] word, input int nbits, output logic [31:0] obs);
    obs = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = word[i];
      repeat (HALF) @(negedge clk);
      obs = {obs[30:0], sdo};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic csb_high_watch(output int nv, output int ne, output int ni, output int lat);
    nv = 0; ne = 0; ni = 0; lat = 0;
    csb = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      nv += int'(frame_valid);
      ne += int'(frame_error);
      ni += int'(cmd_ignored);
      if (lat == 0 && (frame_valid || frame_error || cmd_ignored)) lat = c;
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, output logic [31:0] obs,
                            output int nv, output int ne, output int ni, output int lat);
    csb_low();
    shift_bits(word, nbits, obs);
    csb_high_watch(nv, ne, ni, lat);
  endtask

  function automatic logic [31:0] bitmask(input int nbits);
    return (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
  endfunction

  task automatic test_reset();
    rstn = 1'b0; sck = 1'b0; sdi = 1'b0; csb = 1'b1; clrb = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    vectors++;
    if (dac_code !== 128'd0) begin miscompares++; $display("FAIL reset_dac: got %h want 0", dac_code); end
    vectors++;
    if ({sdo, pd, frame_valid, frame_error, cmd_ignored} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_outs: got sdo=%b pd=%h pulses=%b%b%b want all 0",
               sdo, pd, frame_valid, frame_error, cmd_ignored);
    end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] words [12];
    int          lens  [12];
    logic [31:0] obs, esdo, mask;
    int nv, ne, ni, lat, ev, ee, ei;
    words = '{32'h0033ABCD, 32'h00051234, 32'h00150000, 32'hFF2F8000,
              32'h000002A5, 32'h00376543, 32'h00420000, 32'h00320001,
              32'h00710000, 32'h00091111, 32'h00F00000, 32'h00F5FFFF};
    lens  = '{24, 24, 24, 32, 10, 24, 24, 24, 24, 24, 24, 24};
    for (int k = 0; k < 12; k++) begin
      model_frame(words[k], lens[k], 1'b0, esdo, ev, ee, ei);
      send_frame(words[k], lens[k], obs, nv, ne, ni, lat);
      mask = bitmask(lens[k]);
      vectors++;
      if ((obs & mask) !== (esdo & mask)) begin miscompares++; $display("FAIL dir_sdo[%0d]: got %h want %h", k, obs & mask, esdo & mask); end
      vectors++;
      if ({nv, ne, ni} !== {ev, ee, ei}) begin miscompares++; $display("FAIL dir_pulses[%0d]: got v%0d e%0d i%0d want v%0d e%0d i%0d", k, nv, ne, ni, ev, ee, ei); end
      vectors++;
      if (lat !== LAT) begin miscompares++; $display("FAIL dir_latency[%0d]: got %0d want %0d", k, lat, LAT); end
      vectors++;
      if (dac_code !== exp_dac()) begin miscompares++; $display("FAIL dir_dac[%0d]: got %h want %h", k, dac_code, exp_dac()); end
      vectors++;
      if (pd !== pd_m) begin miscompares++; $display("FAIL dir_pd[%0d]: got %h want %h", k, pd, pd_m); end
    end
  endtask

  task automatic test_random();
    logic [31:0] word, obs, esdo, mask;
    logic [3:0]  c, a;
    int nbits, nv, ne, ni, lat, ev, ee, ei, r;
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3, 4: c = 4'(r);
        5, 6:          c = 4'h3;
        7:             c = 4'hF;
        default:       c = 4'($urandom_range(5, 14));
      endcase
      r = int'($urandom_range(0, 19));
      if (r < 14)      a = 4'($urandom_range(0, 7));
      else if (r < 17) a = 4'hF;
      else             a = 4'($urandom_range(8, 14));
      word = {8'($urandom), c, a, 16'($urandom)};
      r = int'($urandom_range(0, 19));
      nbits = (r < 12) ? 24 : (r < 17) ? 32 : int'($urandom_range(1, 23));
      model_frame(word, nbits, 1'b0, esdo, ev, ee, ei);
      send_frame(word, nbits, obs, nv, ne, ni, lat);
      mask = bitmask(nbits);
      vectors++;
      if ((obs & mask) !== (esdo & mask)) begin miscompares++; $display("FAIL rnd_sdo[%0d]: got %h want %h", k, obs & mask, esdo & mask); end
      vectors++;
      if ({nv, ne, ni} !== {ev, ee, ei}) begin miscompares++; $display("FAIL rnd_pulses[%0d] word %h/%0d: got v%0d e%0d i%0d want v%0d e%0d i%0d", k, word, nbits, nv, ne, ni, ev, ee, ei); end
      vectors++;
      if (lat !== LAT) begin miscompares++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, lat, LAT); end
      vectors++;
      if (dac_code !== exp_dac()) begin miscompares++; $display("FAIL rnd_dac[%0d] word %h: got %h want %h", k, word, dac_code, exp_dac()); end
      vectors++;
      if (pd !== pd_m) begin miscompares++; $display("FAIL rnd_pd[%0d]: got %h want %h", k, pd, pd_m); end
    end
  endtask

  task automatic test_clear();
    logic [31:0] obs, esdo;
    int nv, ne, ni, lat, ev, ee, ei;
    model_frame(32'h002F4321, 24, 1'b0, esdo, ev, ee, ei);
    send_frame(32'h002F4321, 24, obs, nv, ne, ni, lat);
    @(negedge clk) clrb = 1'b0;
    for (int c = 0; c < 8; c++) begin in_m[c] = '0; dac_m[c] = '0; end
    repeat (20) @(negedge clk);
    vectors++;
    if (dac_code !== exp_dac()) begin miscompares++; $display("FAIL clr_hold: got %h want %h", dac_code, exp_dac()); end
    // A frame under clear still pulses and echoes but writes nothing.
    model_frame(32'h00315555, 24, 1'b1, esdo, ev, ee, ei);
    send_frame(32'h00315555, 24, obs, nv, ne, ni, lat);
    vectors++;
    if (obs[23:0] !== esdo[23:0]) begin miscompares++; $display("FAIL clr_sdo: got %h want %h", obs[23:0], esdo[23:0]); end
    vectors++;
    if ({nv, ne, ni, lat} !== {ev, ee, ei, LAT}) begin miscompares++; $display("FAIL clr_pulses: got v%0d e%0d i%0d lat%0d want v%0d e%0d i%0d lat%0d", nv, ne, ni, lat, ev, ee, ei, LAT); end
    vectors++;
    if ({dac_code, pd} !== {exp_dac(), pd_m}) begin miscompares++; $display("FAIL clr_nowrite: got %h/%h want %h/%h", dac_code, pd, exp_dac(), pd_m); end
    @(negedge clk) clrb = 1'b1;
    repeat (8) @(negedge clk);
    model_frame(32'h0031BEEF, 24, 1'b0, esdo, ev, ee, ei);
    send_frame(32'h0031BEEF, 24, obs, nv, ne, ni, lat);
    vectors++;
    if ({dac_code, pd} !== {exp_dac(), pd_m}) begin miscompares++; $display("FAIL clr_after: got %h/%h want %h/%h", dac_code, pd, exp_dac(), pd_m); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] obs, esdo;
    int nv, ne, ni, lat, ev, ee, ei;
    csb_low();
    shift_bits(32'h00000355, 10, obs);
    @(negedge clk) rstn = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({dac_code, pd, sdo} !== {128'd0, 8'd0, 1'b0}) begin miscompares++; $display("FAIL rst_async: got %h/%h/%b want 0", dac_code, pd, sdo); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    shift_bits(32'h00004321, 14, obs);
    csb_high_watch(nv, ne, ni, lat);
    vectors++;
    if (nv + ne + ni !== 0) begin miscompares++; $display("FAIL rst_discard: got %0d pulses want 0", nv + ne + ni); end
    repeat (4) @(negedge clk);
    model_frame(32'h0036C0DE, 24, 1'b0, esdo, ev, ee, ei);
    send_frame(32'h0036C0DE, 24, obs, nv, ne, ni, lat);
    vectors++;
    if (obs[23:0] !== esdo[23:0]) begin miscompares++; $display("FAIL rst_sdo: got %h want %h", obs[23:0], esdo[23:0]); end
    vectors++;
    if ({nv, ne, ni, lat} !== {ev, ee, ei, LAT}) begin miscompares++; $display("FAIL rst_pulses: got v%0d e%0d i%0d lat%0d want v%0d e%0d i%0d lat%0d", nv, ne, ni, lat, ev, ee, ei, LAT); end
    vectors++;
    if (dac_code !== exp_dac()) begin miscompares++; $display("FAIL rst_next: got %h want %h", dac_code, exp_dac()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_clear();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #4ms;
    $display("FAIL timeout: simulation did not complete, got %0d vectors", vectors);
    $fatal(1, "timeout");
  end

endmodule
